vram_fill: RTL

VRAM pattern fill and readback-verify engine. It sits directly upstream of `ram_controller`'s VRAM port and drives the port signals that are currently tied off, so the display path can be brought up against known frame-buffer contents. On a start pulse it writes a selected pattern to every VRAM word. Optionally it then reads every word back, compares it, and reports error count, first failing address and status for the LEDs and seven-segment display.

---
 rtl/vram_fill.sv | 109 ++++++++++
 1 files changed

// File: rtl/vram_fill.sv
// vram_fill: writes a selectable pattern to every VRAM word, optionally reads it back and counts mismatches
module vram_fill #(
    parameter int WORDS          = 24576,
    parameter int ROW_WORDS_LOG2 = 5,
    parameter int TIMEOUT        = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  pattern,
    input  logic        verify,
    output logic [14:0] vram_addr,
    output logic [31:0] vram_data_in,
    input  logic [31:0] vram_data_out,
    output logic        vram_req,
    output logic        vram_write,
    input  logic        vram_ready,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [14:0] err_addr
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_GAP, RD_REQ, RD_GAP, DONE} state_t;

    localparam logic [14:0] LAST_ADDR = 15'(WORDS - 1);
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_next;
    logic        start_q, start_qq, start_edge, last, wait_expired, mismatch, advance;
    logic [1:0]  pattern_q;
    logic        verify_q;
    logic [15:0] wait_cnt;
    logic [14:0] addr_next;

    function automatic logic [31:0] pat_data(input logic [1:0] p, input logic [14:0] a);
        return p == 2'd0 ? 32'h0000_0000 :
               p == 2'd1 ? 32'hFFFF_FFFF :
               p == 2'd2 ? (a[ROW_WORDS_LOG2] ? 32'h5555_5555 : 32'hAAAA_AAAA) :
                           {17'b0, a};
    endfunction

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    // next-state decode and port strobes
    always_comb begin
        state_next   = state;
        start_edge   = start_q & ~start_qq;
        last         = vram_addr == LAST_ADDR;
        wait_expired = wait_cnt == WAIT_LAST;
        mismatch     = vram_data_out != vram_data_in;
        addr_next    = last ? 15'd0 : vram_addr + 15'd1;
        case (state)
            IDLE, DONE: state_next = start_edge ? WR_REQ : state;
            WR_REQ:     state_next = vram_ready ? WR_GAP : wait_expired ? DONE : WR_REQ;
            WR_GAP:     state_next = !last ? WR_REQ : verify_q ? RD_REQ : DONE;
            RD_REQ:     state_next = vram_ready ? RD_GAP : wait_expired ? DONE : RD_REQ;
            RD_GAP:     state_next = last ? DONE : RD_REQ;
            default:    state_next = IDLE;
        endcase
        advance    = (state == WR_GAP || state == RD_GAP) && (state_next == WR_REQ || state_next == RD_REQ);
        vram_req   = state == WR_REQ || state == RD_REQ;
        vram_write = state == WR_REQ;
        busy       = state != IDLE && state != DONE;
        done       = state == DONE;
    end

    // start edge detect, address/data sequencing, wait counter and readback status
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_q      <= 1'b0;
            start_qq     <= 1'b0;
            pattern_q    <= 2'd0;
            verify_q     <= 1'b0;
            wait_cnt     <= 16'd0;
            vram_addr    <= 15'd0;
            vram_data_in <= 32'd0;
            timeout      <= 1'b0;
            err_count    <= 16'd0;
            err_addr     <= 15'd0;
        end else begin
            start_q  <= start;
            start_qq <= start_q;
            wait_cnt <= (vram_req && state_next == state) ? wait_cnt + 16'd1 : 16'd0;
            if ((state == IDLE || state == DONE) && start_edge) begin
                pattern_q    <= pattern;
                verify_q     <= verify;
                vram_addr    <= 15'd0;
                vram_data_in <= pat_data(pattern, 15'd0);
                timeout      <= 1'b0;
                err_count    <= 16'd0;
                err_addr     <= 15'd0;
            end
            if (vram_req && !vram_ready && wait_expired) timeout <= 1'b1;
            if (state == RD_REQ && vram_ready && mismatch) begin
                if (err_count == 16'd0) err_addr <= vram_addr;
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
            end
            if (advance) begin
                vram_addr    <= addr_next;
                vram_data_in <= pat_data(pattern_q, addr_next);
            end
        end
    end
endmodule
